pc_source_unit: RTL and testbench



---
 rtl/pc_source_if.sv | 55 +++++
 rtl/pc_source_unit.sv | 129 ++++++++++++
 tb/tb_pc_source_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pc_source_if.sv
// pc_source_if: bundles the PC source selection, write-enable and exception
// handshake signals between the control/datapath side (master) and the PC
// source unit (slave).
//
// Signals:
//   pc_src_sel    source index into src_bus
//   src_bus       packed candidate PC values, slice i*WIDTH +: WIDTH is source i
//   pc_write      unconditional PC write enable
//   pc_write_cond conditional PC write enable (branches)
//   cond_true     resolved branch condition
//   exc_req       exception request
//   exc_ack       vector fetch acknowledge, returns unit to RUN
//   pc_out        current PC
//   epc_out       saved exception PC
//   exc_busy      high while vectoring
//   sel_err       one-cycle pulse on a write with an out-of-range select
//   align_err     one-cycle pulse on a misaligned write (PC_ALIGN_CHECK_EN only)
interface pc_source_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 8,
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0]      pc_src_sel;
  logic [NSRC*WIDTH-1:0] src_bus;
  logic                  pc_write;
  logic                  pc_write_cond;
  logic                  cond_true;
  logic                  exc_req;
  logic                  exc_ack;
  logic [WIDTH-1:0]      pc_out;
  logic [WIDTH-1:0]      epc_out;
  logic                  exc_busy;
  logic                  sel_err;
`ifdef PC_ALIGN_CHECK_EN
  logic                  align_err;
`endif

  modport master (
    output pc_src_sel, src_bus, pc_write, pc_write_cond, cond_true,
           exc_req, exc_ack,
`ifdef PC_ALIGN_CHECK_EN
    input  align_err,
`endif
    input  pc_out, epc_out, exc_busy, sel_err
  );

  modport slave (
    input  pc_src_sel, src_bus, pc_write, pc_write_cond, cond_true,
           exc_req, exc_ack,
`ifdef PC_ALIGN_CHECK_EN
    output align_err,
`endif
    output pc_out, epc_out, exc_busy, sel_err
  );
endinterface

// File: rtl/pc_source_unit.sv
// pc_source_unit: N-way PC source select combined with the PC register,
// conditional-write logic and exception vectoring with EPC capture.
//
// Ports:
//   clk    system clock, all state updates on rising edge
//   reset  synchronous, active-high reset
//   bus    pc_source_if.slave: select, source bus, write enables, branch
//          condition, exception request/ack, pc_out, epc_out, exc_busy,
//          sel_err (and align_err when enabled)
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   When defined, writes of values with bits [1:0] != 0 are blocked. In RUN
//   such a write is taken as an exception; in VECTOR it is simply dropped.
//   Either way align_err pulses for one cycle.
module pc_source_unit #(
  parameter int               WIDTH    = 32,
  parameter int               NSRC     = 8,
  parameter int               SEL_W    = 3,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_00FC),
  parameter int               PC_INC   = 4
) (
  input logic        clk,
  input logic        reset,
  pc_source_if.slave bus
);

  typedef enum logic {RUN, VECTOR} state_t;

  state_t           state_p1, state_d;
  logic [WIDTH-1:0] pc_p1, pc_d;
  logic [WIDTH-1:0] epc_p1, epc_d;
  logic             sel_err_p1, sel_err_d;
  logic             align_err_p1, align_err_d;

  logic [WIDTH-1:0] sel_val;
  logic             sel_ok;
  logic             wr;
  logic             misaligned;

  // Purely indexed mux; out-of-range selects yield zero and are flagged.
  always_comb begin
    sel_val = '0;
    sel_ok  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.pc_src_sel == SEL_W'(i)) begin
        sel_val = bus.src_bus[i*WIDTH +: WIDTH];
        sel_ok  = 1'b1;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = (sel_val[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Conditional writes are only honoured in RUN; in VECTOR only a plain
  // pc_write (handler fetch) may load the PC.
  assign wr = (state_p1 == RUN) ? (bus.pc_write | (bus.pc_write_cond & bus.cond_true))
                                : bus.pc_write;

  always_comb begin
    state_d     = state_p1;
    pc_d        = pc_p1;
    epc_d       = epc_p1;
    sel_err_d   = 1'b0;
    align_err_d = 1'b0;
    case (state_p1)
      RUN: begin
        if (bus.exc_req) begin
          epc_d   = pc_p1 - WIDTH'(PC_INC);
          pc_d    = EXC_VEC;
          state_d = VECTOR;
        end else if (wr) begin
          if (!sel_ok) begin
            sel_err_d = 1'b1;
          end else if (misaligned) begin
            epc_d       = pc_p1 - WIDTH'(PC_INC);
            pc_d        = EXC_VEC;
            state_d     = VECTOR;
            align_err_d = 1'b1;
          end else begin
            pc_d = sel_val;
          end
        end
      end
      VECTOR: begin
        if (wr) begin
          if (!sel_ok)         sel_err_d   = 1'b1;
          else if (misaligned) align_err_d = 1'b1;
          else                 pc_d        = sel_val;
        end
        if (bus.exc_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // ---- stage p1: architectural registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1     <= RUN;
      pc_p1        <= RESET_PC;
      epc_p1       <= '0;
      sel_err_p1   <= 1'b0;
      align_err_p1 <= 1'b0;
    end else begin
      state_p1     <= state_d;
      pc_p1        <= pc_d;
      epc_p1       <= epc_d;
      sel_err_p1   <= sel_err_d;
      align_err_p1 <= align_err_d;
    end
  end

  assign bus.pc_out   = pc_p1;
  assign bus.epc_out  = epc_p1;
  assign bus.exc_busy = (state_p1 == VECTOR);
  assign bus.sel_err  = sel_err_p1;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.align_err = align_err_p1;
`else
  logic unused_align;
  assign unused_align = align_err_p1 ^ align_err_d;
`endif

endmodule

// File: tb/tb_pc_source_unit.sv
// tb_pc_source_unit: directed bench for pc_source_unit with NSRC=6 so that
// out-of-range selects (6, 7) are reachable. Expected results are queued when
// a step is driven and popped after the clock edge that produces them.
module tb_pc_source_unit;
  localparam int WIDTH = 32;
  localparam int NSRC  = 6;
  localparam int SEL_W = 3;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        busy;
    logic        serr;
    logic        aerr;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [31:0] src_arr [NSRC-1];

  pc_source_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) bus ();

  pc_source_unit #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source 5 carries epc_out back to the mux: the normal return path.
  always_comb begin
    for (int i = 0; i < NSRC - 1; i++) bus.src_bus[i*WIDTH +: WIDTH] = src_arr[i];
    bus.src_bus[(NSRC-1)*WIDTH +: WIDTH] = bus.epc_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] sel,
                      input logic pw, input logic pwc, input logic ct,
                      input logic er, input logic ea, input logic rs,
                      input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_busy, input logic e_serr, input logic e_aerr);
    exp_t e;
    @(negedge clk);
    reset             = rs;
    bus.pc_src_sel    = sel;
    bus.pc_write      = pw;
    bus.pc_write_cond = pwc;
    bus.cond_true     = ct;
    bus.exc_req       = er;
    bus.exc_ack       = ea;
    e.tag = tag; e.pc = e_pc; e.epc = e_epc; e.busy = e_busy; e.serr = e_serr; e.aerr = e_aerr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty got %0d expected 1", tag, sb.size());
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},   bus.pc_out,          e.pc);
      chk({e.tag, ".epc"},  bus.epc_out,         e.epc);
      chk({e.tag, ".busy"}, {31'd0, bus.exc_busy}, {31'd0, e.busy});
      chk({e.tag, ".serr"}, {31'd0, bus.sel_err},  {31'd0, e.serr});
`ifdef PC_ALIGN_CHECK_EN
      chk({e.tag, ".aerr"}, {31'd0, bus.align_err}, {31'd0, e.aerr});
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.pc_src_sel = '0; bus.pc_write = 0; bus.pc_write_cond = 0;
    bus.cond_true = 0; bus.exc_req = 0; bus.exc_ack = 0;
    src_arr[0] = 32'h0000_0100;
    src_arr[1] = 32'h0000_0040;
    src_arr[2] = 32'h0000_0020;
    src_arr[3] = 32'h0000_0300;
    src_arr[4] = 32'h0000_0500;

    //     tag        sel pw pwc ct er ea rs  pc            epc           bsy se ae
    step("reset",     0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      src_arr[i % 5] = $urandom & 32'hFFFF_FFFC;
      step("idle",    i[2:0], 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    end
    src_arr[0] = 32'h0000_0100;
    src_arr[1] = 32'h0000_0040;
    src_arr[2] = 32'h0000_0020;
    src_arr[3] = 32'h0000_0300;
    src_arr[4] = 32'h0000_0102;
    step("wr_s1",     1, 1, 0, 0, 0, 0, 0, 32'h40,       32'h0,        0, 0, 0);
    step("hold",      1, 0, 0, 0, 0, 0, 0, 32'h40,       32'h0,        0, 0, 0);
    step("cond_f",    0, 0, 1, 0, 0, 0, 0, 32'h40,       32'h0,        0, 0, 0);
    step("cond_t",    0, 0, 1, 1, 0, 0, 0, 32'h100,      32'h0,        0, 0, 0);
    step("wr_s2",     2, 1, 0, 0, 0, 0, 0, 32'h20,       32'h0,        0, 0, 0);
    step("exc",       0, 1, 0, 0, 1, 0, 0, 32'hFC,       32'h1C,       1, 0, 0);
    step("exc_nest",  0, 0, 0, 0, 1, 0, 0, 32'hFC,       32'h1C,       1, 0, 0);
    step("vec_cond",  0, 0, 1, 1, 0, 0, 0, 32'hFC,       32'h1C,       1, 0, 0);
    step("vec_wr",    3, 1, 0, 0, 0, 0, 0, 32'h300,      32'h1C,       1, 0, 0);
    step("ack",       0, 0, 0, 0, 0, 1, 0, 32'h300,      32'h1C,       0, 0, 0);
    step("ack_run",   0, 0, 0, 0, 0, 1, 0, 32'h300,      32'h1C,       0, 0, 0);
    step("ret_epc",   5, 1, 0, 0, 0, 0, 0, 32'h1C,       32'h1C,       0, 0, 0);
    step("sel7",      7, 1, 0, 0, 0, 0, 0, 32'h1C,       32'h1C,       0, 1, 0);
    step("sel7_off",  7, 0, 0, 0, 0, 0, 0, 32'h1C,       32'h1C,       0, 0, 0);
    step("sel6",      6, 1, 0, 0, 0, 0, 0, 32'h1C,       32'h1C,       0, 1, 0);
    step("sel6_off",  0, 0, 0, 0, 0, 0, 0, 32'h1C,       32'h1C,       0, 0, 0);
    step("reset2",    0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 0);
    step("exc_pc0",   0, 0, 0, 0, 1, 0, 0, 32'hFC,       32'hFFFF_FFFC, 1, 0, 0);
    step("rst_vec",   0, 1, 0, 0, 1, 1, 1, 32'h0,        32'h0,        0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    step("misal_run", 4, 1, 0, 0, 0, 0, 0, 32'hFC,       32'hFFFF_FFFC, 1, 0, 1);
    step("al_off",    4, 0, 0, 0, 0, 0, 0, 32'hFC,       32'hFFFF_FFFC, 1, 0, 0);
    step("misal_vec", 4, 1, 0, 0, 0, 0, 0, 32'hFC,       32'hFFFF_FFFC, 1, 0, 1);
    step("al_vec_ok", 1, 1, 0, 0, 0, 1, 0, 32'h40,       32'hFFFF_FFFC, 0, 0, 0);
`else
    step("lowbits",   4, 1, 0, 0, 0, 0, 0, 32'h102,      32'h0,        0, 0, 0);
    step("lb_hold",   4, 0, 0, 0, 0, 0, 0, 32'h102,      32'h0,        0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: time %0t limit %0d", $time, 100000);
    $fatal(1, "timeout");
  end
endmodule
